// File: rtl/duck_anim_sequencer.sv
// Per-duck animation sequencer: IDLE -> FLY -> SHOT -> FALL -> IDLE, paced by frame_tick.
// Optional DUCK_ANIM_PINGPONG_EN makes the FLY flap cycle ping-pong instead of wrap.
module duck_anim_sequencer #(
  parameter int unsigned FLAP_FRAMES     = 3,
  parameter int unsigned TICKS_PER_FRAME = 4,
  parameter int unsigned SHOT_HOLD_TICKS = 8,
  parameter int unsigned FALL_TIMEOUT    = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       spawn_req,
  output logic       spawn_ack,
  input  logic       hit,
  input  logic       dir_left,
  input  logic       landed,
  output logic [2:0] frame_sel,
  output logic       mirror,
  output logic       visible,
  output logic [1:0] state,
  output logic       done
);

  localparam int unsigned TICK_W   = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam int unsigned HOLD_MAX = (SHOT_HOLD_TICKS > FALL_TIMEOUT) ? SHOT_HOLD_TICKS : FALL_TIMEOUT;
  localparam int unsigned HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_FRAME - 1);
  localparam logic [HOLD_W-1:0] SHOT_LAST = HOLD_W'(SHOT_HOLD_TICKS - 1);
  localparam logic [HOLD_W-1:0] FALL_LAST = HOLD_W'(FALL_TIMEOUT - 1);
  localparam logic [2:0]        FLAP_LAST  = 3'(FLAP_FRAMES - 1);
  localparam logic [2:0]        SHOT_FRAME = 3'(FLAP_FRAMES);
  localparam logic [2:0]        FALL_A     = 3'(FLAP_FRAMES + 1);
  localparam logic [2:0]        FALL_B     = 3'(FLAP_FRAMES + 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_SHOT = 2'd2,
    ST_FALL = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [2:0]          frame_q, frame_d;
  logic                mirror_q, mirror_d;
  logic                ack_d, done_d;
  logic                tick_wrap;
`ifdef DUCK_ANIM_PINGPONG_EN
  logic                up_q, up_d;
`endif

  assign tick_wrap = frame_tick && (tick_q == TICK_LAST);

  // State and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      hold_q    <= '0;
      frame_q   <= '0;
      mirror_q  <= 1'b0;
      visible   <= 1'b0;
      spawn_ack <= 1'b0;
      done      <= 1'b0;
`ifdef DUCK_ANIM_PINGPONG_EN
      up_q      <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      hold_q    <= hold_d;
      frame_q   <= frame_d;
      mirror_q  <= mirror_d;
      visible   <= (state_d != ST_IDLE);
      spawn_ack <= ack_d;
      done      <= done_d;
`ifdef DUCK_ANIM_PINGPONG_EN
      up_q      <= up_d;
`endif
    end
  end

  // Next-state, counters and frame selection
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    hold_d   = hold_q;
    frame_d  = frame_q;
    mirror_d = mirror_q;
    ack_d    = 1'b0;
    done_d   = 1'b0;
`ifdef DUCK_ANIM_PINGPONG_EN
    up_d     = up_q;
`endif
    case (state_q)
      ST_IDLE: begin
        frame_d = 3'd0;
        if (spawn_req) begin
          state_d  = ST_FLY;
          ack_d    = 1'b1;
          tick_d   = '0;
          hold_d   = '0;
          mirror_d = dir_left;
`ifdef DUCK_ANIM_PINGPONG_EN
          up_d     = 1'b1;
`endif
        end
      end
      ST_FLY: begin
        // hit beats a coincident frame advance and freezes mirror
        if (hit) begin
          state_d = ST_SHOT;
          frame_d = SHOT_FRAME;
          hold_d  = '0;
        end else if (tick_wrap) begin
          tick_d   = '0;
          mirror_d = dir_left;
`ifdef DUCK_ANIM_PINGPONG_EN
          if (up_q) begin
            if (frame_q == FLAP_LAST) begin
              frame_d = frame_q - 3'd1;
              up_d    = 1'b0;
            end else begin
              frame_d = frame_q + 3'd1;
            end
          end else begin
            if (frame_q == 3'd0) begin
              frame_d = 3'd1;
              up_d    = 1'b1;
            end else begin
              frame_d = frame_q - 3'd1;
            end
          end
`else
          frame_d = (frame_q == FLAP_LAST) ? 3'd0 : frame_q + 3'd1;
`endif
        end else if (frame_tick) begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      ST_SHOT: begin
        if (frame_tick) begin
          if (hold_q == SHOT_LAST) begin
            state_d = ST_FALL;
            frame_d = FALL_A;
            tick_d  = '0;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      ST_FALL: begin
        if (landed || (frame_tick && (hold_q == FALL_LAST))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          frame_d = 3'd0;
          tick_d  = '0;
          hold_d  = '0;
        end else if (frame_tick) begin
          hold_d = hold_q + HOLD_W'(1);
          if (tick_wrap) begin
            tick_d  = '0;
            frame_d = (frame_q == FALL_A) ? FALL_B : FALL_A;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign frame_sel = frame_q;
  assign mirror    = mirror_q;
  assign state     = state_q;

endmodule
